// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MA stage, the secondary (DMA/debug) requester,
// the data-memory arbiter and the DMEM instance.
// Handshake: a requester raises *_req with its fields and holds them stable
// until completion; the CPU sees completion as cpu_req & ~cpu_stall, the
// secondary port as a one-cycle dma_gnt pulse. Read data is valid only in
// that completion cycle.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic [2:0]  dma_funct3;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_funct3, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_funct3, mem_addr, mem_wdata
    );

    // Environment view (requesters and memory)
    modport master (
        output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_funct3, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_funct3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares single-port DMEM between the CPU MA stage and a
// secondary requester, sequences wait-stated accesses and stalls the CPU while
// it does not own a completing access. Arbitration happens only in IDLE; the
// secondary port is forced through after STARVE_LIMIT consecutive CPU grants.
module dmem_arbiter #(
    parameter int WAIT_STATES  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    dmem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state,
    output logic [3:0]   dbg_starve_cnt
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);
    localparam logic [3:0] SL = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_next;
    logic [2:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic       grant_cpu;
    logic       grant_dma;
    logic       own_cpu;
    logic       own_dma;
    logic       complete;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Arbitration, ownership and completion detection
    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        own_cpu   = 1'b0;
        own_dma   = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                grant_dma = bus.dma_req && ((starve_cnt == SL) || !bus.cpu_req);
                grant_cpu = bus.cpu_req && !grant_dma;
                own_cpu   = grant_cpu;
                own_dma   = grant_dma;
                complete  = (WS == 3'd0) && (grant_cpu || grant_dma);
            end
            BUSY_CPU: begin
                own_cpu  = 1'b1;
                complete = (wait_cnt == WS);
            end
            BUSY_DMA: begin
                own_dma  = 1'b1;
                complete = (wait_cnt == WS);
            end
            default: ;
        endcase
    end

    // Next-state: zero-wait accesses finish in IDLE, others park in BUSY_x
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (WS != 3'd0) begin
                    if (grant_cpu)      state_next = BUSY_CPU;
                    else if (grant_dma) state_next = BUSY_DMA;
                end
            end
            BUSY_CPU, BUSY_DMA: begin
                if (complete) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: memory mux, single write pulse, stall and grant
    always_comb begin
        if (own_dma) begin
            bus.mem_funct3 = bus.dma_funct3;
            bus.mem_addr   = bus.dma_addr;
            bus.mem_wdata  = bus.dma_wdata;
        end else begin
            bus.mem_funct3 = bus.cpu_funct3;
            bus.mem_addr   = bus.cpu_addr;
            bus.mem_wdata  = bus.cpu_wdata;
        end
        bus.mem_we     = reset_n && complete &&
                         ((own_dma && bus.dma_we) || (own_cpu && bus.cpu_we));
        bus.cpu_stall  = reset_n && bus.cpu_req && !(own_cpu && complete);
        bus.dma_gnt    = reset_n && own_dma && complete;
        bus.dma_rvalid = reset_n && own_dma && complete && !bus.dma_we;
        bus.cpu_rdata  = bus.mem_rdata;
        bus.dma_rdata  = bus.mem_rdata;
    end

    // Wait-state counter: 1 on entering BUSY_x, cleared on completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           wait_cnt <= 3'd0;
        else if (complete || state_next == IDLE) wait_cnt <= 3'd0;
        else                                     wait_cnt <= wait_cnt + 3'd1;
    end

    // Starvation counter: CPU grants while the secondary port waits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          starve_cnt <= 4'd0;
        else if (!bus.dma_req || grant_dma)    starve_cnt <= 4'd0;
        else if (grant_cpu && starve_cnt != SL) starve_cnt <= starve_cnt + 4'd1;
    end

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;
endmodule
